// File: rtl/compressor_pkg.sv
// Shared helpers for the pipelined carry-save compressor tree.
//   MAX_OPS    : largest supported operand count.
//   vecs_after : vector count left after a given number of 3:2 layers.
//   num_layers : 3:2 layers needed to reduce n vectors down to two.
package compressor_pkg;

    localparam int MAX_OPS = 32;

    // Each layer turns every full group of three into two vectors and
    // passes the leftovers through untouched.
    function automatic int vecs_after(input int n, input int layers);
        int v;
        v = n;
        for (int i = 0; i < layers; i++) begin
            v = 2 * (v / 3) + (v % 3);
        end
        return v;
    endfunction

    function automatic int num_layers(input int n);
        int v;
        int l;
        v = n;
        l = 0;
        while (v > 2) begin
            v = 2 * (v / 3) + (v % 3);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_layer.sv
// One combinational 3:2 reduction layer.
// Ports:
//   in_vecs  : N_IN packed WIDTH-bit vectors, vector i at [i*WIDTH +: WIDTH].
//   out_vecs : vecs_after(N_IN,1) packed vectors. Group g of three inputs
//              produces sum at slot 2g and shifted carry at slot 2g+1;
//              leftover inputs follow in index order.
module csa_layer
    import compressor_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N_IN  = 3
) (
    input  logic [N_IN*WIDTH-1:0]                 in_vecs,
    output logic [vecs_after(N_IN, 1)*WIDTH-1:0]  out_vecs
);

    localparam int GROUPS = N_IN / 3;
    localparam int REM    = N_IN % 3;

    for (genvar g = 0; g < GROUPS; g++) begin : g_fa
        logic [WIDTH-1:0] a, b, c, maj;
        assign a   = in_vecs[(3*g)*WIDTH   +: WIDTH];
        assign b   = in_vecs[(3*g+1)*WIDTH +: WIDTH];
        assign c   = in_vecs[(3*g+2)*WIDTH +: WIDTH];
        assign maj = (a & b) | (a & c) | (b & c);
        assign out_vecs[(2*g)*WIDTH   +: WIDTH] = a ^ b ^ c;
        // Carry weight is one bit higher; the carry out of the MSB is
        // dropped, which keeps everything modulo 2^WIDTH.
        assign out_vecs[(2*g+1)*WIDTH +: WIDTH] = maj << 1;
    end

    for (genvar r = 0; r < REM; r++) begin : g_pass
        assign out_vecs[(2*GROUPS+r)*WIDTH +: WIDTH] =
            in_vecs[(3*GROUPS+r)*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/pipelined_compressor_tree.sv
// Pipelined compressor tree: reduces NUM_OPS operands to a carry-save pair
// (RESOLVE=0) or a single resolved sum (RESOLVE=1), one registered stage per
// layer, with a valid/ready handshake that collapses bubbles.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset.
//   flush_i                 : synchronous clear of all in-flight results.
//   in_valid_i / in_ready_o : input handshake; in_ops_i holds packed operands.
//   out_valid_o/out_ready_i : output handshake.
//   out_sum_o, out_carry_o  : result pair (carry is 0 when RESOLVE=1).
module pipelined_compressor_tree
    import compressor_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NUM_OPS = 15,
    parameter int RESOLVE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_sum_o,
    output logic [WIDTH-1:0]         out_carry_o
);

    localparam int NUM_LAYERS = num_layers(NUM_OPS);
    localparam int NUM_STAGES = NUM_LAYERS + ((RESOLVE != 0) ? 1 : 0);

    logic [NUM_STAGES-1:0] vld_p;   // valid bit of each stage register
    logic [NUM_STAGES-1:0] vld_in;  // valid arriving at each stage
    logic [NUM_STAGES-1:0] load;    // stage register may capture this cycle

    // A stage can load if it, or any stage downstream of it, is empty, or
    // the consumer is taking the output; this is the unrolled form of
    // "own valid is 0 or the next stage is loading".
    always_comb begin
        logic open_slot;
        open_slot = out_ready_i;
        load      = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            open_slot = open_slot | ~vld_p[k];
            load[k]   = open_slot;
        end
    end

    always_comb begin
        vld_in    = '0;
        vld_in[0] = in_valid_i;
        for (int k = 1; k < NUM_STAGES; k++) begin
            vld_in[k] = vld_p[k-1];
        end
    end

    assign in_ready_o = load[0] & ~flush_i;

    // Flush wins over any concurrent accept or advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (flush_i) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p & ~load) | (vld_in & load);
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int N_IN  = vecs_after(NUM_OPS, k);
        localparam int N_OUT = (k < NUM_LAYERS) ? vecs_after(NUM_OPS, k + 1) : 1;

        logic [N_IN*WIDTH-1:0]  d;
        logic [N_OUT*WIDTH-1:0] nxt;
        logic [N_OUT*WIDTH-1:0] data_p;

        if (k == 0) begin : g_src_in
            assign d = in_ops_i;
        end else begin : g_src_prev
            assign d = g_stage[k-1].data_p;
        end

        if (k < NUM_LAYERS) begin : g_csa
            csa_layer #(
                .WIDTH (WIDTH),
                .N_IN  (N_IN)
            ) u_csa (
                .in_vecs  (d),
                .out_vecs (nxt)
            );
        end else begin : g_cpa
            assign nxt = d[WIDTH-1:0] + d[2*WIDTH-1:WIDTH];
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_p <= '0;
            end else if (load[k] && vld_in[k]) begin
                data_p <= nxt;
            end
        end
    end

    assign out_valid_o = vld_p[NUM_STAGES-1];

    if (RESOLVE != 0) begin : g_out_resolved
        assign out_sum_o   = g_stage[NUM_STAGES-1].data_p;
        assign out_carry_o = '0;
    end else begin : g_out_pair
        assign out_sum_o   = g_stage[NUM_STAGES-1].data_p[WIDTH-1:0];
        assign out_carry_o = g_stage[NUM_STAGES-1].data_p[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_pipelined_compressor_tree.sv
// Directed bench for pipelined_compressor_tree (15 x 64-bit). A second
// instance with RESOLVE=1 shares the stimulus for the resolved-sum cases.
module tb_pipelined_compressor_tree;

    localparam int W = 64;
    localparam int N = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, flush, in_valid, out_ready;
    logic [N*W-1:0] in_ops;
    logic [W-1:0]   ops [N];
    logic           in_ready, out_valid;
    logic [W-1:0]   out_sum, out_carry;
    logic           in_ready_r, out_valid_r;
    logic [W-1:0]   out_sum_r, out_carry_r;

    int n_tests = 0;
    int n_fail  = 0;

    always_comb begin
        in_ops = '0;
        for (int k = 0; k < N; k++) in_ops[k*W +: W] = ops[k];
    end

    pipelined_compressor_tree #(.WIDTH(W), .NUM_OPS(N), .RESOLVE(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_ops_i(in_ops), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_sum_o(out_sum), .out_carry_o(out_carry));

    pipelined_compressor_tree #(.WIDTH(W), .NUM_OPS(N), .RESOLVE(1)) dut_res (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_r), .in_ops_i(in_ops), .out_valid_o(out_valid_r),
        .out_ready_i(out_ready), .out_sum_o(out_sum_r), .out_carry_o(out_carry_r));

    function automatic logic [W-1:0] golden();
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s += ops[k];
        return s;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < N; k++) ops[k] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", out_sum); end
        n_tests++; if (out_carry !== '0) begin n_fail++; $display("FAIL reset_carry: got %h want 0", out_carry); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_valid_r !== 1'b0) begin n_fail++; $display("FAIL reset_valid_res: got %b want 0", out_valid_r); end
    endtask

    // Single operand set with no backpressure; ops must be loaded by caller.
    task automatic test_latency(input string name, input logic [W-1:0] exp);
        int lat, lat_r;
        logic [W-1:0] s;
        lat = 0; lat_r = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept: in_ready %b want 1", name, in_ready); end
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 1) in_valid = 1'b0;
            if (out_valid && lat == 0) begin
                lat = c;
                s = out_sum + out_carry;
                n_tests++; if (s !== exp) begin n_fail++; $display("FAIL %s_sum: got %h want %h", name, s, exp); end
            end
            if (out_valid_r && lat_r == 0) begin
                lat_r = c;
                n_tests++; if (out_sum_r !== exp) begin n_fail++; $display("FAIL %s_res_sum: got %h want %h", name, out_sum_r, exp); end
                n_tests++; if (out_carry_r !== '0) begin n_fail++; $display("FAIL %s_res_carry: got %h want 0", name, out_carry_r); end
            end
        end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL %s_latency: got %0d want 6", name, lat); end
        n_tests++; if (lat_r != 7) begin n_fail++; $display("FAIL %s_res_latency: got %0d want 7", name, lat_r); end
    endtask

    task automatic test_single_op();
        do_reset();
        for (int k = 0; k < N; k++) ops[k] = W'(k + 1);
        test_latency("ramp", 64'd120);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < N; k++) ops[k] = 64'hFFFF_FFFF_FFFF_FFFF;
        test_latency("wrap", 64'hFFFF_FFFF_FFFF_FFF1);
    endtask

    task automatic test_backpressure();
        int acc;
        logic [W-1:0] s, e;
        do_reset();
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < N; k++) ops[k] = W'((acc + 1) * (k + 1));
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            next_cycle();
        end
        #1;
        n_tests++; if (acc != 6) begin n_fail++; $display("FAIL bp_accepted: got %0d want 6", acc); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            s = out_sum + out_carry;
            e = W'((c + 1) * 120);
            n_tests++; if (out_valid !== 1'b1 || s !== e) begin n_fail++; $display("FAIL bp_drain%0d: valid %b sum %h want %h", c, out_valid, s, e); end
            next_cycle();
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: valid %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [W-1:0] exp_q [$];
        logic [3:0]   pat;
        logic [W-1:0] s, e, held_s, held_c;
        logic         held, need_new;
        int sent, got;
        do_reset();
        pat = 4'b1001;
        sent = 0; got = 0; held = 1'b0; need_new = 1'b1;
        held_s = '0; held_c = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = pat[cyc % 4];
            if (sent < 20) begin
                if (need_new) begin
                    for (int k = 0; k < N; k++) ops[k] = {$urandom(), $urandom()};
                    need_new = 1'b0;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_sum !== held_s || out_carry !== held_c) begin
                    n_fail++;
                    $display("FAIL stream_hold: valid %b sum %h carry %h want %h %h", out_valid, out_sum, out_carry, held_s, held_c);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden());
                sent++;
                need_new = 1'b1;
            end
            if (out_valid && out_ready) begin
                s = out_sum + out_carry;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got %h want no output", s);
                end else begin
                    e = exp_q.pop_front();
                    if (s !== e) begin n_fail++; $display("FAIL stream_item%0d: got %h want %h", got, s, e); end
                end
                got++;
            end
            held = out_valid && !out_ready;
            held_s = out_sum; held_c = out_carry;
            next_cycle();
            if (got >= 20 && sent >= 20) break;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) next_cycle();
        n_tests++; if (got != 20) begin n_fail++; $display("FAIL stream_count: got %0d want 20", got); end
        n_tests++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL stream_tail: valid %b pending %0d want 0 0", out_valid, exp_q.size()); end
    endtask

    task automatic test_flush();
        int seen;
        logic [W-1:0] s;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < N; k++) ops[k] = W'(100 * (i + 1) + k);
            in_valid = 1'b1;
            next_cycle();
        end
        for (int k = 0; k < N; k++) ops[k] = 64'd999;
        flush = 1'b1; in_valid = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
        for (int k = 0; k < N; k++) ops[k] = W'(5 * (k + 1));
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) begin
                seen++;
                s = out_sum + out_carry;
                n_tests++; if (s !== 64'd600) begin n_fail++; $display("FAIL flush_post_item: got %h want %h", s, 64'd600); end
            end
            next_cycle();
        end
        n_tests++; if (seen != 1) begin n_fail++; $display("FAIL flush_post_count: got %0d want 1", seen); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < N; k++) ops[k] = W'(3 * (k + 1));
        repeat (8) next_cycle();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_sum + out_carry !== 64'd360) begin n_fail++; $display("FAIL arst_pre_full: valid %b sum %h want 1 %h", out_valid, out_sum + out_carry, 64'd360); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        n_tests++; if (out_sum !== '0 || out_carry !== '0) begin n_fail++; $display("FAIL arst_data: got %h %h want 0 0", out_sum, out_carry); end
        n_tests++; if (out_valid_r !== 1'b0 || out_sum_r !== '0) begin n_fail++; $display("FAIL arst_res: got %b %h want 0 0", out_valid_r, out_sum_r); end
        #2 rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_output%0d: got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < N; k++) ops[k] = '0;
        test_reset();
        test_single_op();
        test_wrap();
        test_backpressure();
        test_stream();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
